// File: rtl/msgPass_config_pkg.sv
// -----------------------------------------------------------------------------
// msgPass_config_pkg
// Shared configuration for the message-passing datapath: buffer geometry,
// number of increment sources, and the types used by the buffer scheduler
// (FSM state encoding and the burst command record).
// -----------------------------------------------------------------------------
package msgPass_config_pkg;

  localparam int MSGPASS_BUFF_ADDR_WIDTH  = 7;
  localparam int MSGPASS_BUFF_RDATA_WIDTH = 15;
  localparam int INCREMENT_SRC_NUM        = 2;
  localparam int MSGPASS_SCHED_ID_WIDTH   = $clog2(INCREMENT_SRC_NUM);

  typedef enum logic {SCHED_IDLE, SCHED_BURST} msgpass_sched_state_t;

  typedef struct packed {
    logic                               we;
    logic [MSGPASS_BUFF_ADDR_WIDTH-1:0] base;
    logic [MSGPASS_BUFF_ADDR_WIDTH-1:0] len;
  } msgpass_burst_cmd_t;

  // Round-robin successor of a requester index, wrapping at num.
  function automatic int rr_next(input int id, input int num);
    return (id + 1 >= num) ? 0 : id + 1;
  endfunction

endpackage

// File: rtl/msgpass_rr_arb.sv
// -----------------------------------------------------------------------------
// msgpass_rr_arb
// Combinational round-robin arbiter. The search starts at rr_ptr and walks
// upward (wrapping) until a pending requester is found.
// Ports:
//   req_valid  in   REQ_NUM   pending request per requester
//   rr_ptr     in   ID_WIDTH  first index to consider
//   any_valid  out  1         at least one request pending
//   win_id     out  ID_WIDTH  winning requester (0 when none pending)
//   win_onehot out  REQ_NUM   one-hot form of win_id, all zero when none
// -----------------------------------------------------------------------------
module msgpass_rr_arb #(
  parameter int REQ_NUM  = 2,
  parameter int ID_WIDTH = $clog2(REQ_NUM)
) (
  input  logic [REQ_NUM-1:0]  req_valid,
  input  logic [ID_WIDTH-1:0] rr_ptr,
  output logic                any_valid,
  output logic [ID_WIDTH-1:0] win_id,
  output logic [REQ_NUM-1:0]  win_onehot
);

  assign any_valid = |req_valid;

  always_comb begin
    logic found;
    int   idx;
    win_id = '0;
    found  = 1'b0;
    idx    = 0;
    for (int i = 0; i < REQ_NUM; i++) begin
      idx = (int'(rr_ptr) + i) % REQ_NUM;
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        win_id = ID_WIDTH'(idx);
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < REQ_NUM; gi++) begin : g_onehot
      assign win_onehot[gi] = any_valid && (win_id == ID_WIDTH'(gi));
    end
  endgenerate

endmodule

// File: rtl/msgpass_buff_sched.sv
// -----------------------------------------------------------------------------
// msgpass_buff_sched
// Burst scheduler sharing the single-port message-passing buffer between
// REQ_NUM requesters. In IDLE a round-robin winner is accepted (one-cycle
// req_ready pulse), then BURST issues one buffer beat per cycle at
// base, base+1, ... (wrapping) until len+1 beats are done. Read data comes
// back one cycle after each read beat and is tagged with the owner's ID.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   req_valid/req_we          per-requester command pending / write burst
//   req_base/req_len          per-requester start address / beats minus 1
//   req_ready                 command-accept pulse (IDLE only)
//   wr_data / wr_beat         per-requester write word / word consumed
//   burst_done                pulse with the last beat of a burst
//   buff_en/buff_we/buff_addr/buff_wdata  buffer access
//   buff_rdata                buffer read data (1-cycle latency)
//   rd_valid/rd_id/rd_data    tagged read return
// -----------------------------------------------------------------------------
module msgpass_buff_sched
  import msgPass_config_pkg::*;
#(
  parameter int ADDR_WIDTH = MSGPASS_BUFF_ADDR_WIDTH,
  parameter int DATA_WIDTH = MSGPASS_BUFF_RDATA_WIDTH,
  parameter int REQ_NUM    = INCREMENT_SRC_NUM,
  parameter int ID_WIDTH   = $clog2(REQ_NUM)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [REQ_NUM-1:0]            req_valid,
  input  logic [REQ_NUM-1:0]            req_we,
  input  logic [REQ_NUM*ADDR_WIDTH-1:0] req_base,
  input  logic [REQ_NUM*ADDR_WIDTH-1:0] req_len,
  output logic [REQ_NUM-1:0]            req_ready,
  input  logic [REQ_NUM*DATA_WIDTH-1:0] wr_data,
  output logic [REQ_NUM-1:0]            wr_beat,
  output logic [REQ_NUM-1:0]            burst_done,
  output logic                          buff_en,
  output logic                          buff_we,
  output logic [ADDR_WIDTH-1:0]         buff_addr,
  output logic [DATA_WIDTH-1:0]         buff_wdata,
  input  logic [DATA_WIDTH-1:0]         buff_rdata,
  output logic                          rd_valid,
  output logic [ID_WIDTH-1:0]           rd_id,
  output logic [DATA_WIDTH-1:0]         rd_data
);

  msgpass_sched_state_t  state_reg;
  logic [ID_WIDTH-1:0]   gnt_reg;
  logic [ID_WIDTH-1:0]   rr_ptr_reg;
  logic [ID_WIDTH-1:0]   rr_ptr_next;
  logic                  we_reg;
  logic [ADDR_WIDTH-1:0] base_reg;
  logic [ADDR_WIDTH-1:0] len_reg;
  logic [ADDR_WIDTH-1:0] beat_cnt_reg;
  logic                  rd_valid_reg;
  logic [ID_WIDTH-1:0]   rd_id_reg;

  logic                  arb_any;
  logic [ID_WIDTH-1:0]   arb_win_id;
  logic [REQ_NUM-1:0]    arb_onehot;

  logic                  busy;
  logic                  last_beat;

  // Per-requester views of the flattened command/data buses.
  logic [ADDR_WIDTH-1:0] base_arr  [REQ_NUM];
  logic [ADDR_WIDTH-1:0] len_arr   [REQ_NUM];
  logic [DATA_WIDTH-1:0] wdata_arr [REQ_NUM];

  genvar gi;
  generate
    for (gi = 0; gi < REQ_NUM; gi++) begin : g_unpack
      assign base_arr[gi]  = req_base[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign len_arr[gi]   = req_len[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign wdata_arr[gi] = wr_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  msgpass_rr_arb #(
    .REQ_NUM  (REQ_NUM),
    .ID_WIDTH (ID_WIDTH)
  ) u_rr_arb (
    .req_valid  (req_valid),
    .rr_ptr     (rr_ptr_reg),
    .any_valid  (arb_any),
    .win_id     (arb_win_id),
    .win_onehot (arb_onehot)
  );

  assign rr_ptr_next = ID_WIDTH'(rr_next(int'(arb_win_id), REQ_NUM));

  assign busy      = (state_reg == SCHED_BURST);
  assign last_beat = busy && (beat_cnt_reg == len_reg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= SCHED_IDLE;
      gnt_reg      <= '0;
      rr_ptr_reg   <= '0;
      we_reg       <= 1'b0;
      base_reg     <= '0;
      len_reg      <= '0;
      beat_cnt_reg <= '0;
      rd_valid_reg <= 1'b0;
      rd_id_reg    <= '0;
    end else begin
      rd_valid_reg <= buff_en & ~buff_we;
      rd_id_reg    <= gnt_reg;
      case (state_reg)
        SCHED_IDLE: begin
          if (arb_any) begin
            gnt_reg      <= arb_win_id;
            we_reg       <= req_we[arb_win_id];
            base_reg     <= base_arr[arb_win_id];
            len_reg      <= len_arr[arb_win_id];
            beat_cnt_reg <= '0;
            rr_ptr_reg   <= rr_ptr_next;
            state_reg    <= SCHED_BURST;
          end
        end
        SCHED_BURST: begin
          if (beat_cnt_reg == len_reg) begin
            state_reg <= SCHED_IDLE;
          end else begin
            beat_cnt_reg <= beat_cnt_reg + 1'b1;
          end
        end
        default: state_reg <= SCHED_IDLE;
      endcase
    end
  end

  // Accept is only offered from IDLE and is held off while reset is applied,
  // so a command presented during reset is never considered taken.
  assign req_ready = (!rst && state_reg == SCHED_IDLE) ? arb_onehot : '0;

  assign buff_en    = busy;
  assign buff_we    = busy & we_reg;
  assign buff_addr  = busy ? ADDR_WIDTH'(base_reg + beat_cnt_reg) : '0;
  assign buff_wdata = buff_we ? wdata_arr[gnt_reg] : '0;

  generate
    for (gi = 0; gi < REQ_NUM; gi++) begin : g_owner
      assign wr_beat[gi]    = buff_we   && (gnt_reg == ID_WIDTH'(gi));
      assign burst_done[gi] = last_beat && (gnt_reg == ID_WIDTH'(gi));
    end
  endgenerate

  assign rd_valid = rd_valid_reg;
  assign rd_id    = rd_id_reg;
  assign rd_data  = buff_rdata;

endmodule
